// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module   : bp_be_pkg
// Purpose  : Shared back-end types for the integer multiply pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bp_be_pkg;

  typedef enum logic [2:0] {
    e_imul_mul    = 3'd0,
    e_imul_mulh   = 3'd1,
    e_imul_mulhsu = 3'd2,
    e_imul_mulhu  = 3'd3
  } bp_be_imul_op_e;

endpackage

`default_nettype wire

// File: rtl/bp_be_pipe_valid_chain.sv
// ============================================================================
// Module   : bp_be_pipe_valid_chain
// Purpose  : Per-stage valid shift register with kill-all and occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_be_pipe_valid_chain #(
  parameter int latency_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  input  logic                           kill_i,
  output logic                           v_o,
  output logic [$clog2(latency_p+1)-1:0] count_o
);

  localparam int c_cnt_w = $clog2(latency_p+1);

  logic [latency_p-1:0] r_valid;
  logic [c_cnt_w-1:0]   r_count;

  // Kill wins over a same-cycle issue; the retiring stage is not affected
  // because its result is already on the outputs this cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (kill_i) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid[0] <= v_i;
      for (int i = 1; i < latency_p; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
      r_count <= r_count + c_cnt_w'(v_i) - c_cnt_w'(r_valid[latency_p-1]);
    end
  end

  assign v_o     = r_valid[latency_p-1];
  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bsg_dff_chain.sv
// ============================================================================
// Module   : bsg_dff_chain
// Purpose  : Unreset register chain, left free for retiming by synthesis.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bsg_dff_chain #(
  parameter int width_p      = 8,
  parameter int num_stages_p = 1
) (
  input  logic               clk_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_stage [num_stages_p];

  always_ff @(posedge clk_i) begin
    r_stage[0] <= data_i;
  end

  for (genvar g = 1; g < num_stages_p; g++) begin : g_stage
    always_ff @(posedge clk_i) begin
      r_stage[g] <= r_stage[g-1];
    end
  end

  assign data_o = r_stage[num_stages_p-1];

endmodule

`default_nettype wire

// File: rtl/bp_be_pipe_imul_gen.sv
// ============================================================================
// Module   : bp_be_pipe_imul_gen
// Purpose  : Fixed-latency integer multiply pipe (mul/mulh/mulhsu/mulhu, word).
// Revision : 1.0
// ============================================================================
`default_nettype none

module bp_be_pipe_imul_gen
  import bp_be_pkg::*;
#(
  parameter int width_p     = 64,
  parameter int latency_p   = 4,
  parameter int tag_width_p = 5
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  input  bp_be_imul_op_e                 op_i,
  input  logic                           opw_i,
  input  logic [width_p-1:0]             rs1_i,
  input  logic [width_p-1:0]             rs2_i,
  input  logic [tag_width_p-1:0]         tag_i,
  input  logic                           flush_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  output logic [tag_width_p-1:0]         tag_o,
  output logic [$clog2(latency_p+1)-1:0] inflight_o,
  output logic                           busy_o
);

  localparam int c_half = width_p / 2;

  logic                           w_a_signed;
  logic                           w_b_signed;
  logic        [width_p:0]        w_a;
  logic        [width_p:0]        w_b;
  logic signed [2*width_p-1:0]    w_a_ext;
  logic signed [2*width_p-1:0]    w_b_ext;
  logic        [2*width_p-1:0]    w_prod;
  logic        [width_p-1:0]      w_result;
  logic [width_p+tag_width_p-1:0] w_chain_out;

  // Word mode only needs the low half of the product, so any extension of the
  // low operand halves yields the right bits.
  always_comb begin
    w_a_signed = (op_i == e_imul_mulh) || (op_i == e_imul_mulhsu);
    w_b_signed = (op_i == e_imul_mulh);
    if (opw_i) begin
      w_a = {{(c_half+1){rs1_i[c_half-1]}}, rs1_i[c_half-1:0]};
      w_b = {{(c_half+1){rs2_i[c_half-1]}}, rs2_i[c_half-1:0]};
    end else begin
      w_a = {w_a_signed & rs1_i[width_p-1], rs1_i};
      w_b = {w_b_signed & rs2_i[width_p-1], rs2_i};
    end
  end

  // One (width_p+1)-bit signed multiply; only 2*width_p product bits are kept.
  assign w_a_ext = {{(width_p-1){w_a[width_p]}}, w_a};
  assign w_b_ext = {{(width_p-1){w_b[width_p]}}, w_b};
  assign w_prod  = w_a_ext * w_b_ext;

  always_comb begin
    if (op_i == e_imul_mul) begin
      w_result = opw_i ? {{c_half{w_prod[c_half-1]}}, w_prod[c_half-1:0]}
                       : w_prod[width_p-1:0];
    end else begin
      w_result = w_prod[2*width_p-1:width_p];
    end
  end

  bsg_dff_chain #(
    .width_p      (width_p + tag_width_p),
    .num_stages_p (latency_p)
  ) u_data_chain (
    .clk_i  (clk_i),
    .data_i ({w_result, tag_i}),
    .data_o (w_chain_out)
  );

  bp_be_pipe_valid_chain #(
    .latency_p (latency_p)
  ) u_valid_chain (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .kill_i    (flush_i),
    .v_o       (v_o),
    .count_o   (inflight_o)
  );

  assign data_o = w_chain_out[width_p+tag_width_p-1:tag_width_p];
  assign tag_o  = w_chain_out[tag_width_p-1:0];
  assign busy_o = (inflight_o != '0);

endmodule

`default_nettype wire

// File: doc/bp_be_pipe_imul_gen.md
BP_BE_PIPE_IMUL_GEN -- requirements
Module: bp_be_pipe_imul_gen

Interface
REQ-001 Parameter width_p, default 64: operand/result width; even, >=8.
REQ-002 Parameter latency_p, default 4: issue-to-result cycles; >=1.
REQ-003 Parameter tag_width_p, default 5: opaque tag carried with each op.
REQ-004 clk_i  input  1  sole clock; all state on rising edge.
REQ-005 reset_n_i  input  1  asynchronous, active-low reset.
REQ-006 v_i  input  1  op issued this cycle; always accepted, no backpressure.
REQ-007 op_i  input  3  bp_be_imul_op_e: mul, mulh, mulhsu, mulhu.
REQ-008 opw_i  input  1  word mode: operate on low width_p/2 bits.
REQ-009 rs1_i, rs2_i  input  width_p each  operands.
REQ-010 tag_i  input  tag_width_p  tag for issued op.
REQ-011 flush_i  input  1  kill all younger in-flight ops.
REQ-012 v_o  output  1  result valid.
REQ-013 data_o  output  width_p  result.
REQ-014 tag_o  output  tag_width_p  tag of returned op.
REQ-015 inflight_o  output  $clog2(latency_p+1)  count of live ops in pipe.
REQ-016 busy_o  output  1  inflight_o != 0.

Function
REQ-017 Op with v_i=1 at cycle t SHALL produce v_o=1 with its data_o/tag_o at cycle t+latency_p, unless killed.
REQ-018 Pipe SHALL accept one op per cycle back-to-back; results return in issue order.
REQ-019 mul: low width_p bits of rs1*rs2.
REQ-020 mulh: high width_p bits of signed*signed full 2*width_p product.
REQ-021 mulhsu: high bits of signed rs1 * unsigned rs2.
REQ-022 mulhu: high bits of unsigned*unsigned.
REQ-023 opw_i=1 with mul: low width_p/2 bits of product of low halves, sign-extended to width_p; opw_i=1 with mulh* is illegal, result unspecified, v_o still returned.
REQ-024 flush_i=1 at cycle t SHALL clear valid of every stage and of an op issued at t; no v_o for those ops at t+1..t+latency_p.
REQ-025 An op whose v_o is high at cycle t SHALL still be delivered regardless of flush_i at t.
REQ-026 Issue and flush in same cycle: issued op is killed.
REQ-027 inflight_o SHALL equal number of valid stages: +1 on unkilled issue, -1 on retire, both same cycle -> unchanged, flush -> 0 next cycle; never exceeds latency_p.
REQ-028 data_o/tag_o are don't-care when v_o=0; killed stages need not clear data.
REQ-029 latency_p=1 SHALL be legal: one register stage after multiply.

Reset
REQ-030 While reset_n_i=0: v_o=0, inflight_o=0, busy_o=0; all stage valids 0, asynchronously.
REQ-031 Data/tag registers need no reset.
REQ-032 Ops in flight at reset assertion SHALL be discarded; first issue after deassertion returns normally at +latency_p.

Structure
REQ-033 bp_be_imul_op_e (e_imul_mul=0, e_imul_mulh=1, e_imul_mulhsu=2, e_imul_mulhu=3) SHALL live in bp_be_pkg.
REQ-034 Valid path SHALL be a sub-module bp_be_pipe_valid_chain (width-1 shift register, async active-low reset, synchronous kill-all input, occupancy counter); data/tag path SHALL be a bsg_dff_chain of latency_p stages, not reset, for synthesis retiming.
REQ-035 Multiply SHALL be a single (width_p+1)x(width_p+1) signed product with operand sign extension selected by op; no per-op multipliers.

Verification
REQ-036 width_p=64, latency_p=4: mul rs1=0xFFFFFFFFFFFFFFFF, rs2=2, tag=3 at t=0 -> v_o=1 at t=4, data_o=0xFFFFFFFFFFFFFFFE, tag_o=3.
REQ-037 mulh -1*-1 -> 0; mulhu 0xFFFFFFFFFFFFFFFF*0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE; mulhsu -1*2 -> 0xFFFFFFFFFFFFFFFF.
REQ-038 mul opw=1 rs1=0x0000000080000000, rs2=1 -> 0xFFFFFFFF80000000.
REQ-039 Issue tags 0..3 at t=0..3, flush_i at t=4 (issue tag 4 same cycle) -> tag 0 delivered at t=4, no v_o t=5..8, inflight_o=0 at t=5.
REQ-040 Issue every cycle for 20 cycles with random ops vs. golden model -> in-order, exact results, inflight_o=4 steady state; reset_n_i low mid-stream -> v_o=0 immediately, no stale results after release.
